// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared register-file constants and types for the write-port arbiter and
// its scoreboard.
//   RF_AW    : register address width
//   RF_DW    : register data width
//   RF_N     : number of architectural registers
//   ZERO_REG : hard-wired zero register; writes to it are dropped and it
//              is never reserved
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;
    localparam int RF_N  = 32;

    typedef logic [RF_AW-1:0] rf_addr_t;
    typedef logic [RF_DW-1:0] rf_data_t;

    localparam rf_addr_t ZERO_REG = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// Tracks destination registers reserved by long-latency (src1) operations
// and flags read hazards for the two decode source operands.
//
// Optional feature macro: RF_WB_BYPASS_EN
//   When defined, a register whose write is in the output stage is reported
//   through byp_hitN_o / byp_dataN_o instead of raising hzN_o.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   rsv_valid_i       reservation request from issue
//   rsv_reg_i         register to reserve
//   rsv_ready_o       reservation accepted (reg not already pending, or r0)
//   clr_en_i          src1 write transferred this cycle
//   clr_reg_i         destination of that src1 write
//   chk_reg1_i/2_i    decode source registers
//   rf_wr_i           output-stage write enable (from the arbiter)
//   wr_reg_i          output-stage write address
//   wr_data_i         output-stage write data (bypass build only)
//   byp_hit1_o/2_o    operand available from the output stage (bypass only)
//   byp_data1_o/2_o   bypassed operand value (bypass only)
//   hz1_o, hz2_o      operand not yet readable; decode must stall
// ---------------------------------------------------------------------------
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     rsv_valid_i,
    input  rf_addr_t rsv_reg_i,
    output logic     rsv_ready_o,
    input  logic     clr_en_i,
    input  rf_addr_t clr_reg_i,
    input  rf_addr_t chk_reg1_i,
    input  rf_addr_t chk_reg2_i,
    input  logic     rf_wr_i,
    input  rf_addr_t wr_reg_i,
`ifdef RF_WB_BYPASS_EN
    input  rf_data_t wr_data_i,
    output logic     byp_hit1_o,
    output logic     byp_hit2_o,
    output rf_data_t byp_data1_o,
    output rf_data_t byp_data2_o,
`endif
    output logic     hz1_o,
    output logic     hz2_o
);

    logic [RF_N-1:0] pending_q;
    logic [RF_N-1:0] pending_d;
    logic            inflight1;
    logic            inflight2;

    // A pending register must first be released by its src1 write before it
    // can be reserved again (WAW stall). r0 is always accepted, never stored.
    assign rsv_ready_o = !pending_q[rsv_reg_i] || (rsv_reg_i == ZERO_REG);

    // Clear first, then set: a same-cycle reserve of the register being
    // released leaves it pending.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) begin
            pending_d[clr_reg_i] = 1'b0;
        end
        if (rsv_valid_i && rsv_ready_o && (rsv_reg_i != ZERO_REG)) begin
            pending_d[rsv_reg_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // The output stage has not committed yet, so the rf still holds the old
    // value for a register being written this cycle.
    assign inflight1 = rf_wr_i && (wr_reg_i == chk_reg1_i);
    assign inflight2 = rf_wr_i && (wr_reg_i == chk_reg2_i);

`ifdef RF_WB_BYPASS_EN
    assign hz1_o       = (chk_reg1_i != ZERO_REG) && pending_q[chk_reg1_i];
    assign hz2_o       = (chk_reg2_i != ZERO_REG) && pending_q[chk_reg2_i];
    assign byp_hit1_o  = (chk_reg1_i != ZERO_REG) && inflight1;
    assign byp_hit2_o  = (chk_reg2_i != ZERO_REG) && inflight2;
    assign byp_data1_o = wr_data_i;
    assign byp_data2_o = wr_data_i;
`else
    assign hz1_o = (chk_reg1_i != ZERO_REG) && (pending_q[chk_reg1_i] || inflight1);
    assign hz2_o = (chk_reg2_i != ZERO_REG) && (pending_q[chk_reg2_i] || inflight2);
`endif

endmodule

// File: rtl/rf_wb_arb.sv
// ---------------------------------------------------------------------------
// rf_wb_arb
// Shares the single register-file write port between the in-order pipeline
// writeback (src0) and a long-latency unit (src1), with a starvation guard
// for src1, a one-cycle output register, and a reservation scoreboard that
// reports read hazards to decode.
//
// Handshake (all three request channels): a transfer happens on a rising
// edge where valid && ready. ready is combinational from the current valid
// inputs and state; a source keeps reg/data stable while valid && !ready.
//
// Optional feature macro: RF_WB_BYPASS_EN (adds byp_hit*/byp_data* outputs
// and removes the in-flight term from hz1/hz2).
//
// Parameters:
//   STARVE_LIMIT  consecutive src1 denial cycles before src1 wins one (1..15)
// Ports:
//   clk, rst                       clock, async active-high reset
//   wb0_valid/ready/reg/data       src0 (pipeline writeback) write channel
//   wb1_valid/ready/reg/data       src1 (long-latency unit) write channel
//   rsv_valid/ready/reg            destination reservation from issue
//   chk_reg1, chk_reg2             decode source registers
//   hz1, hz2                       decode stall flags
//   byp_hit1/2, byp_data1/2        output-stage bypass (RF_WB_BYPASS_EN)
//   rf_wr, wr_reg, wr_data         register-file write port
// ---------------------------------------------------------------------------
module rf_wb_arb
    import rf_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     wb0_valid,
    output logic     wb0_ready,
    input  rf_addr_t wb0_reg,
    input  rf_data_t wb0_data,
    input  logic     wb1_valid,
    output logic     wb1_ready,
    input  rf_addr_t wb1_reg,
    input  rf_data_t wb1_data,
    input  logic     rsv_valid,
    output logic     rsv_ready,
    input  rf_addr_t rsv_reg,
    input  rf_addr_t chk_reg1,
    input  rf_addr_t chk_reg2,
    output logic     hz1,
    output logic     hz2,
`ifdef RF_WB_BYPASS_EN
    output logic     byp_hit1,
    output logic     byp_hit2,
    output rf_data_t byp_data1,
    output rf_data_t byp_data2,
`endif
    output logic     rf_wr,
    output rf_addr_t wr_reg,
    output rf_data_t wr_data
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_q;
    logic [3:0] starve_d;
    logic       force_win;
    logic       wb0_fire;
    logic       wb1_fire;
    logic       rf_wr_q;
    rf_addr_t   wr_reg_q;
    rf_data_t   wr_data_q;

    // src1 wins only when src0 is idle or after LIMIT denied cycles in a row.
    assign force_win = (starve_q == LIMIT);
    assign wb1_ready = wb1_valid && (!wb0_valid || force_win);
    assign wb0_ready = wb0_valid && !(force_win && wb1_valid);
    assign wb0_fire  = wb0_valid && wb0_ready;
    assign wb1_fire  = wb1_valid && wb1_ready;

    // Counts consecutive denials; any src1 transfer or idle cycle clears it.
    always_comb begin
        starve_d = '0;
        if (wb1_valid && !wb1_ready) begin
            starve_d = force_win ? starve_q : starve_q + 4'd1;
        end
    end

    // Output register. A transfer to r0 completes the handshake but never
    // raises rf_wr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q  <= '0;
            rf_wr_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            starve_q <= starve_d;
            if (wb0_fire) begin
                rf_wr_q   <= (wb0_reg != ZERO_REG);
                wr_reg_q  <= wb0_reg;
                wr_data_q <= wb0_data;
            end else if (wb1_fire) begin
                rf_wr_q   <= (wb1_reg != ZERO_REG);
                wr_reg_q  <= wb1_reg;
                wr_data_q <= wb1_data;
            end else begin
                rf_wr_q <= 1'b0;
            end
        end
    end

    assign rf_wr   = rf_wr_q;
    assign wr_reg  = wr_reg_q;
    assign wr_data = wr_data_q;

    rf_scoreboard u_sb (
        .clk_i       (clk),
        .rst_i       (rst),
        .rsv_valid_i (rsv_valid),
        .rsv_reg_i   (rsv_reg),
        .rsv_ready_o (rsv_ready),
        .clr_en_i    (wb1_fire),
        .clr_reg_i   (wb1_reg),
        .chk_reg1_i  (chk_reg1),
        .chk_reg2_i  (chk_reg2),
        .rf_wr_i     (rf_wr_q),
        .wr_reg_i    (wr_reg_q),
`ifdef RF_WB_BYPASS_EN
        .wr_data_i   (wr_data_q),
        .byp_hit1_o  (byp_hit1),
        .byp_hit2_o  (byp_hit2),
        .byp_data1_o (byp_data1),
        .byp_data2_o (byp_data2),
`endif
        .hz1_o       (hz1),
        .hz2_o       (hz2)
    );

endmodule

// File: tb/tb_rf_wb_arb.sv
module tb_rf_wb_arb;

    localparam int STARVE_LIMIT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        wb0_valid = 1'b0, wb1_valid = 1'b0, rsv_valid = 1'b0;
    logic        wb0_ready, wb1_ready, rsv_ready;
    logic [4:0]  wb0_reg = '0, wb1_reg = '0, rsv_reg = '0;
    logic [31:0] wb0_data = '0, wb1_data = '0;
    logic [4:0]  chk_reg1 = '0, chk_reg2 = '0;
    logic        hz1, hz2, rf_wr;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
`ifdef RF_WB_BYPASS_EN
    logic        byp_hit1, byp_hit2;
    logic [31:0] byp_data1, byp_data2;
`endif

    rf_wb_arb #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb0_valid (wb0_valid),
        .wb0_ready (wb0_ready),
        .wb0_reg   (wb0_reg),
        .wb0_data  (wb0_data),
        .wb1_valid (wb1_valid),
        .wb1_ready (wb1_ready),
        .wb1_reg   (wb1_reg),
        .wb1_data  (wb1_data),
        .rsv_valid (rsv_valid),
        .rsv_ready (rsv_ready),
        .rsv_reg   (rsv_reg),
        .chk_reg1  (chk_reg1),
        .chk_reg2  (chk_reg2),
        .hz1       (hz1),
        .hz2       (hz2),
`ifdef RF_WB_BYPASS_EN
        .byp_hit1  (byp_hit1),
        .byp_hit2  (byp_hit2),
        .byp_data1 (byp_data1),
        .byp_data2 (byp_data2),
`endif
        .rf_wr     (rf_wr),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Set of reserved registers, length of the current src1 denial streak,
    // and the write currently sitting in the output stage.
    bit [31:0]   m_pend;
    int          m_starve;
    bit          m_rf_wr;
    logic [4:0]  m_wr_reg;
    logic [36:0] exp_q[$];   // {reg, data} of writes that must reach the rf

    // accepted flags of the last cycle (for holding stimulus)
    bit acc0, acc1, accr;

    // snapshot of DUT outputs at the last sample point
    logic        obs_wb0_rdy, obs_wb1_rdy, obs_rsv_rdy, obs_hz1, obs_hz2, obs_rf_wr;
    logic [4:0]  obs_wr_reg;
    logic [31:0] obs_wr_data;

    task automatic model_reset();
        m_pend   = '0;
        m_starve = 0;
        m_rf_wr  = 1'b0;
        m_wr_reg = '0;
        exp_q.delete();
        acc0 = 1'b0;
        acc1 = 1'b0;
        accr = 1'b0;
    endtask

    function automatic bit exp_hz(input logic [4:0] c);
        if (c == 0) return 1'b0;
        if (m_pend[c]) return 1'b1;
`ifdef RF_WB_BYPASS_EN
        return 1'b0;
`else
        return m_rf_wr && (m_wr_reg == c);
`endif
    endfunction

    // One clock cycle: called at posedge+1 with inputs already driven.
    task automatic step();
        bit          frc, e0, e1, er;
        logic [36:0] w;
        #2;
        frc = (m_starve == STARVE_LIMIT);
        e1  = wb1_valid && (!wb0_valid || frc);
        e0  = wb0_valid && !(frc && wb1_valid);
        er  = !m_pend[rsv_reg] || (rsv_reg == 0);

        obs_wb0_rdy = wb0_ready;  obs_wb1_rdy = wb1_ready;  obs_rsv_rdy = rsv_ready;
        obs_hz1 = hz1;  obs_hz2 = hz2;  obs_rf_wr = rf_wr;
        obs_wr_reg = wr_reg;  obs_wr_data = wr_data;

        check("wb0_ready", 64'(wb0_ready), 64'(e0));
        check("wb1_ready", 64'(wb1_ready), 64'(e1));
        check("rsv_ready", 64'(rsv_ready), 64'(er));
        check("hz1", 64'(hz1), 64'(exp_hz(chk_reg1)));
        check("hz2", 64'(hz2), 64'(exp_hz(chk_reg2)));
        check("rf_wr", 64'(rf_wr), 64'(m_rf_wr));
        if (m_rf_wr && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check("wr_reg_data", 64'({wr_reg, wr_data}), 64'(w));
        end
`ifdef RF_WB_BYPASS_EN
        check("byp_hit1", 64'(byp_hit1), 64'(m_rf_wr && m_wr_reg == chk_reg1 && chk_reg1 != 0));
        check("byp_hit2", 64'(byp_hit2), 64'(m_rf_wr && m_wr_reg == chk_reg2 && chk_reg2 != 0));
        if (m_rf_wr) begin
            check("byp_data1", 64'(byp_data1), 64'(wr_data));
            check("byp_data2", 64'(byp_data2), 64'(wr_data));
        end
`endif

        // advance the model with this cycle's transfers
        acc0 = e0;
        acc1 = e1;
        accr = rsv_valid && er;
        if (wb1_valid && !e1) begin
            if (m_starve < STARVE_LIMIT) m_starve++;
        end else begin
            m_starve = 0;
        end
        if (e1) m_pend[wb1_reg] = 1'b0;
        if (accr && rsv_reg != 0) m_pend[rsv_reg] = 1'b1;
        m_rf_wr = 1'b0;
        if (e0) begin
            m_rf_wr  = (wb0_reg != 0);
            m_wr_reg = wb0_reg;
            if (wb0_reg != 0) exp_q.push_back({wb0_reg, wb0_data});
        end else if (e1) begin
            m_rf_wr  = (wb1_reg != 0);
            m_wr_reg = wb1_reg;
            if (wb1_reg != 0) exp_q.push_back({wb1_reg, wb1_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
        rsv_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        check("reset_rf_wr", 64'(rf_wr), 64'(0));
        check("reset_wr_reg", 64'(wr_reg), 64'(0));
        check("reset_wr_data", 64'(wr_data), 64'(0));

        // single src0 write
        wb0_valid = 1'b1; wb0_reg = 5'd3; wb0_data = 32'hDEADBEEF;
        step();
        check("s0_ready", 64'(obs_wb0_rdy), 64'(1));
        idle_inputs();
        step();
        check("s0_rf_wr_t1", 64'(obs_rf_wr), 64'(1));
        check("s0_wr_reg_t1", 64'(obs_wr_reg), 64'(3));
        check("s0_wr_data_t1", 64'(obs_wr_data), 64'(32'hDEADBEEF));
        step();
        check("s0_rf_wr_t2", 64'(obs_rf_wr), 64'(0));

        // both sources continuously valid: src1 wins every 5th cycle
        wb0_valid = 1'b1; wb0_reg = 5'd1;
        wb1_valid = 1'b1; wb1_reg = 5'd9; wb1_data = 32'h5A5A0009;
        for (int k = 0; k < 10; k++) begin
            wb0_data = $urandom;
            step();
            check("starve_wb0", 64'(obs_wb0_rdy), 64'((k % 5 == 4) ? 0 : 1));
            check("starve_wb1", 64'(obs_wb1_rdy), 64'((k % 5 == 4) ? 1 : 0));
        end
        idle_inputs();
        step();
        step();

        // reservation, hazard, WAW stall
        chk_reg1 = 5'd7; chk_reg2 = 5'd8;
        rsv_valid = 1'b1; rsv_reg = 5'd7;
        step();
        check("rsv7_ready", 64'(obs_rsv_rdy), 64'(1));
        rsv_valid = 1'b0;
        step();
        check("rsv7_hz1", 64'(obs_hz1), 64'(1));
        rsv_valid = 1'b1; rsv_reg = 5'd7;
        step();
        check("rsv7_waw", 64'(obs_rsv_rdy), 64'(0));
        wb1_valid = 1'b1; wb1_reg = 5'd7; wb1_data = 32'hCAFE0007;
        step();
        check("wb1_7_ready", 64'(obs_wb1_rdy), 64'(1));
        check("wb1_7_hz1", 64'(obs_hz1), 64'(1));
        wb1_valid = 1'b0;
        step();
        check("wb1_7_rf_wr", 64'(obs_rf_wr), 64'(1));
        check("wb1_7_wr_reg", 64'(obs_wr_reg), 64'(7));
`ifdef RF_WB_BYPASS_EN
        check("wb1_7_hz1_inflight", 64'(obs_hz1), 64'(0));
`else
        check("wb1_7_hz1_inflight", 64'(obs_hz1), 64'(1));
`endif
        check("rsv7_retry_ready", 64'(obs_rsv_rdy), 64'(1));
        rsv_valid = 1'b0;
        step();
        check("rsv7_repend_hz1", 64'(obs_hz1), 64'(1));

        // same-cycle release and reserve of reg 8: set wins
        wb1_valid = 1'b1; wb1_reg = 5'd8; wb1_data = 32'h00000088;
        rsv_valid = 1'b1; rsv_reg = 5'd8;
        step();
        idle_inputs();
        step();
        step();
        check("set_wins_hz2", 64'(obs_hz2), 64'(1));

        // register 0
        wb0_valid = 1'b1; wb0_reg = 5'd0; wb0_data = 32'h00001234;
        step();
        check("r0_ready", 64'(obs_wb0_rdy), 64'(1));
        wb0_valid = 1'b0;
        rsv_valid = 1'b1; rsv_reg = 5'd0; chk_reg1 = 5'd0;
        step();
        check("r0_rf_wr", 64'(obs_rf_wr), 64'(0));
        check("r0_rsv_ready", 64'(obs_rsv_rdy), 64'(1));
        check("r0_hz1", 64'(obs_hz1), 64'(0));
        rsv_valid = 1'b0;
        step();

        // reset mid-write
        wb0_valid = 1'b1; wb0_reg = 5'd5; wb0_data = 32'h55555555;
        step();
        wb0_valid = 1'b0;
        #1;
        check("pre_rst_rf_wr", 64'(rf_wr), 64'(1));
        rst = 1'b1;
        #1;
        check("rst_rf_wr", 64'(rf_wr), 64'(0));
        check("rst_wr_reg", 64'(wr_reg), 64'(0));
        check("rst_wr_data", 64'(wr_data), 64'(0));
        for (int c = 0; c < 32; c++) begin
            chk_reg1 = 5'(c);
            #1;
            check("rst_hz1", 64'(hz1), 64'(0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // randomized traffic; held requests stay stable until accepted
        for (int i = 0; i < 1500; i++) begin
            if (!(wb0_valid && !acc0)) begin
                wb0_valid = ($urandom_range(0, 3) != 0);
                wb0_reg   = 5'($urandom_range(0, 7));
                wb0_data  = $urandom;
            end
            if (!(wb1_valid && !acc1)) begin
                wb1_valid = ($urandom_range(0, 1) != 0);
                wb1_reg   = 5'($urandom_range(0, 7));
                wb1_data  = $urandom;
            end
            if (!(rsv_valid && !accr)) begin
                rsv_valid = ($urandom_range(0, 2) == 0);
                rsv_reg   = 5'($urandom_range(0, 7));
            end
            chk_reg1 = 5'($urandom_range(0, 7));
            chk_reg2 = 5'($urandom_range(0, 7));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
